cache_mem_arbiter: RTL and testbench

- Arbitrates the single shared main-memory port between I-cache and D-cache line-miss traffic for the pipelined MIPS core.
- Sits between the two cache controllers and the memory model.
- Sequences one memory transaction at a time and returns read lines to the owning cache.
- Default priority goes to D-cache; the optional mode is round-robin.

---
 rtl/cache_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared main-memory port between I-cache and D-cache line misses.
// Define ARB_RR_EN for round-robin arbitration; otherwise D-cache has fixed priority.
module cache_mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;

    state_t            state, state_n;
    logic              mem_read_n, mem_write_n, i_ready_n, d_ready_n, busy_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [LINE_W-1:0] mem_wdata_n, i_rdata_n, d_rdata_n;
    logic              d_req, grant_d;

    assign d_req = d_read | d_write;

`ifdef ARB_RR_EN
    // last_served: 1 = D-cache, 0 = I-cache
    logic last_served, last_served_n;
    assign grant_d = d_req && (!i_read || !last_served);
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        state_n     = state;
        mem_read_n  = mem_read;
        mem_write_n = mem_write;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        i_rdata_n   = i_rdata;
        d_rdata_n   = d_rdata;
        i_ready_n   = 1'b0;
        d_ready_n   = 1'b0;
`ifdef ARB_RR_EN
        last_served_n = last_served;
`endif
        case (state)
            IDLE: begin
                if (grant_d) begin
                    mem_addr_n  = d_addr;
                    mem_wdata_n = d_wdata;
                    mem_write_n = d_write;
                    mem_read_n  = !d_write;
                    state_n     = SERVE_D;
`ifdef ARB_RR_EN
                    last_served_n = 1'b1;
`endif
                end else if (i_read) begin
                    mem_addr_n  = i_addr;
                    mem_read_n  = 1'b1;
                    mem_write_n = 1'b0;
                    state_n     = SERVE_I;
`ifdef ARB_RR_EN
                    last_served_n = 1'b0;
`endif
                end
            end
            SERVE_I: begin
                if (mem_ready) begin
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                    i_ready_n   = 1'b1;
                    i_rdata_n   = mem_rdata;
                    state_n     = RESP;
                end
            end
            SERVE_D: begin
                if (mem_ready) begin
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                    d_ready_n   = 1'b1;
                    // a write-back leaves the last returned line in place
                    if (mem_read) d_rdata_n = mem_rdata;
                    state_n     = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            busy      <= 1'b0;
`ifdef ARB_RR_EN
            last_served <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            mem_read  <= mem_read_n;
            mem_write <= mem_write_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            i_rdata   <= i_rdata_n;
            d_rdata   <= d_rdata_n;
            i_ready   <= i_ready_n;
            d_ready   <= d_ready_n;
            busy      <= busy_n;
`ifdef ARB_RR_EN
            last_served <= last_served_n;
`endif
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: a memory model checks each transaction,
// a monitor checks each ready pulse against queued expected responses.
module tb_cache_mem_arbiter;

    logic         clk, rst;
    logic         i_read, i_ready, d_read, d_write, d_ready;
    logic [27:0]  i_addr, d_addr, mem_addr;
    logic [127:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic         mem_read, mem_write, mem_ready, busy;

    cache_mem_arbiter #(.ADDR_W(28), .LINE_W(128)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
        int           lat;
    } mem_t;

    typedef struct {
        bit           port_d;
        logic [127:0] data;
    } resp_t;

    mem_t  mem_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    n_ready = 0;
    int    poke_req = 0;
    int    poke_done = 0;

    localparam logic [127:0] BAD = {4{32'hBAD0BAD0}};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_mem(input bit wr, input logic [27:0] a, input logic [127:0] wd,
                            input logic [127:0] rd, input int lat);
        mem_t m;
        m.wr = wr; m.addr = a; m.wdata = wd; m.rdata = rd; m.lat = lat;
        mem_q.push_back(m);
    endtask

    task automatic push_resp(input bit port_d, input logic [127:0] data);
        resp_t r;
        r.port_d = port_d; r.data = data;
        resp_q.push_back(r);
    endtask

    // Memory model: checks the issued transaction, then answers after m.lat edges
    initial begin
        mem_t m;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (poke_req != poke_done) begin
                poke_done++;
                mem_rdata = {4{32'hFFFF0000}};
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
            end else if (mem_read || mem_write) begin
                if (mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_unexpected: got addr %h expected no transaction", mem_addr);
                    m.wr = mem_write; m.addr = mem_addr; m.wdata = '0; m.rdata = BAD; m.lat = 1;
                end else begin
                    m = mem_q.pop_front();
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_strobes", {mem_write, mem_read}, {m.wr, !m.wr});
                    if (m.wr) chk("mem_wdata", mem_wdata, m.wdata);
                end
                for (int k = 1; k < m.lat; k++) begin
                    @(negedge clk);
                    chk("mem_hold_addr", mem_addr, m.addr);
                    chk("mem_hold_strobes", {mem_write, mem_read}, {m.wr, !m.wr});
                end
                mem_rdata = m.rdata;
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
    end

    // Response monitor
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (i_ready && d_ready) begin
                checks++; errors++;
                $display("FAIL both_ready: got i_ready=1 d_ready=1 expected one at a time");
            end
            if (i_ready || d_ready) begin
                n_ready++;
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected: got i_ready=%0d d_ready=%0d expected none", i_ready, d_ready);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_port", d_ready, r.port_d);
                    chk("resp_data", d_ready ? d_rdata : i_rdata, r.data);
                end
            end
        end
    end

    task automatic req_i(input logic [27:0] a, input int exp_cyc);
        int n = 0;
        i_addr = a;
        i_read = 1'b1;
        do begin @(negedge clk); n++; end while (!i_ready && n < 60);
        i_read = 1'b0;
        if (!i_ready) begin
            checks++; errors++;
            $display("FAIL i_timeout: got no i_ready in %0d cycles expected a pulse", n);
        end else if (exp_cyc > 0) chk("i_latency", n, exp_cyc);
    endtask

    task automatic req_d(input bit rd, input bit wr, input logic [27:0] a,
                         input logic [127:0] wd, input int exp_cyc);
        int n = 0;
        d_addr  = a;
        d_wdata = wd;
        d_read  = rd;
        d_write = wr;
        do begin @(negedge clk); n++; end while (!d_ready && n < 60);
        d_read  = 1'b0;
        d_write = 1'b0;
        if (!d_ready) begin
            checks++; errors++;
            $display("FAIL d_timeout: got no d_ready in %0d cycles expected a pulse", n);
        end else if (exp_cyc > 0) chk("d_latency", n, exp_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset then idle
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_ready", {i_ready, d_ready}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst = 1'b0;
        poke_req++;
        repeat (4) @(negedge clk);
        chk("idle_no_ready", n_ready, 0);
        chk("idle_busy", busy, 0);

        // I-cache read with 3-cycle memory
        push_mem(0, 28'h0000040, '0, 128'hDEADBEEF_00000001_00000002_00000003, 3);
        push_resp(0, 128'hDEADBEEF_00000001_00000002_00000003);
        req_i(28'h0000040, 4);
        chk("i_read_d_rdata_kept", d_rdata, 0);
        repeat (2) @(negedge clk);

        // D-cache write-back, 1-cycle memory
        push_mem(1, 28'h0000100, {4{32'h11111111}}, BAD, 1);
        push_resp(1, '0);
        req_d(0, 1, 28'h0000100, {4{32'h11111111}}, 2);
        repeat (2) @(negedge clk);

        // Reset while SERVE_D coincides with mem_ready
        push_mem(0, 28'h0000300, '0, BAD, 1);
        d_addr = 28'h0000300;
        d_read = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_read && n < 20);
        chk("mid_grant", mem_read, 1);
        rst = 1'b1;
        d_read = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_d_ready", d_ready, 0);
        chk("mid_rst_mem_read", mem_read, 0);
        chk("mid_rst_d_rdata", d_rdata, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Contention: I pending while D issues two back-to-back reads
`ifdef ARB_RR_EN
        push_mem(0, 28'h0000020, '0, {4{32'hD020D020}}, 1);
        push_mem(0, 28'h0000010, '0, {4{32'h10101010}}, 1);
        push_mem(0, 28'h0000030, '0, {4{32'hD030D030}}, 1);
        push_resp(1, {4{32'hD020D020}});
        push_resp(0, {4{32'h10101010}});
        push_resp(1, {4{32'hD030D030}});
`else
        push_mem(0, 28'h0000020, '0, {4{32'hD020D020}}, 1);
        push_mem(0, 28'h0000030, '0, {4{32'hD030D030}}, 1);
        push_mem(0, 28'h0000010, '0, {4{32'h10101010}}, 1);
        push_resp(1, {4{32'hD020D020}});
        push_resp(1, {4{32'hD030D030}});
        push_resp(0, {4{32'h10101010}});
`endif
        fork
            req_i(28'h0000010, 0);
            begin
                req_d(1, 0, 28'h0000020, '0, 0);
                req_d(1, 0, 28'h0000030, '0, 0);
            end
        join
        repeat (2) @(negedge clk);

        // d_read and d_write together: write-back only, d_rdata kept
        push_mem(1, 28'h0000200, {4{32'h22222222}}, BAD, 2);
        push_resp(1, {4{32'hD030D030}});
        req_d(1, 1, 28'h0000200, {4{32'h22222222}}, 3);

        n = 0;
        while ((mem_q.size() != 0 || resp_q.size() != 0) && n < 100) begin
            @(negedge clk); n++;
        end
        repeat (3) @(negedge clk);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);
        chk("ready_count", n_ready, 6);
        chk("end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
